// File: rtl/bcd_conv_arbiter.sv
// Shares one bit-serial 40-bit binary-to-BCD converter among N_REQ requesters.
// Round-robin grant, operand held on conv_in from grant until the next grant.
module bcd_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [40*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [39:0]           resp_bcd,
  output logic                  busy,
  output logic                  conv_trigger,
  output logic [39:0]           conv_in,
  input  logic                  conv_idle,
  input  logic [39:0]           conv_bcd
);

  // state       | meaning
  // S_SYNC      | wait for converter idle (converter is not reset with us)
  // S_ARB       | block free, round-robin arbitration
  // S_LAUNCH    | operand latched, trigger pulse being issued
  // S_WAIT_BUSY | wait for converter to leave idle
  // S_WAIT_DONE | wait for converter to return to idle, then take result
  // S_RESP      | one-cycle result pulse to the granted requester

  typedef enum logic [2:0] {
    S_SYNC, S_ARB, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_RESP
  } state_t;

  localparam int SW = ID_W + 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [ID_W-1:0]   gnt, idx;
  logic [SW-1:0]     sum;
  logic              found;

  logic [N_REQ-1:0]  req_ready_nxt, resp_valid_nxt;
  logic [ID_W-1:0]   resp_id_nxt;
  logic [39:0]       resp_bcd_nxt, conv_in_nxt;
  logic              conv_trigger_nxt;

  // Search ptr+1, ptr+2, ... with explicit wrap so non power-of-two N_REQ never
  // selects an index past the last requester.
  always_comb begin
    found = 1'b0;
    gnt   = ptr;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      idx = sum[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    ptr_nxt          = ptr;
    req_ready_nxt    = '0;
    resp_valid_nxt   = '0;
    resp_id_nxt      = resp_id;
    resp_bcd_nxt     = resp_bcd;
    conv_trigger_nxt = 1'b0;
    conv_in_nxt      = conv_in;
    case (state)
      S_SYNC: if (conv_idle) state_nxt = S_ARB;
      S_ARB: begin
        if (found) begin
          req_ready_nxt = ONE << gnt;
          conv_in_nxt   = req_data[40*gnt +: 40];
          ptr_nxt       = gnt;
          state_nxt     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        conv_trigger_nxt = 1'b1;
        state_nxt        = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!conv_idle) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (conv_idle) begin
          resp_bcd_nxt   = conv_bcd;
          resp_valid_nxt = ONE << ptr;
          resp_id_nxt    = ptr;
          state_nxt      = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_ARB;
      default: state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_SYNC;
      ptr          <= ID_W'(N_REQ - 1);
      req_ready    <= '0;
      resp_valid   <= '0;
      resp_id      <= '0;
      resp_bcd     <= '0;
      conv_trigger <= 1'b0;
      conv_in      <= '0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      req_ready    <= req_ready_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_id      <= resp_id_nxt;
      resp_bcd     <= resp_bcd_nxt;
      conv_trigger <= conv_trigger_nxt;
      conv_in      <= conv_in_nxt;
    end
  end

  assign busy = (state != S_ARB);

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one 40-bit double-dabble binary-to-BCD converter among N_REQ requesters, e.g. display/UART formatting units of the vector coprocessor.
- Arbitrates requests round-robin and latches the selected operand.
- Sequences the converter's trigger/idle handshake.
- Returns the BCD result tagged with the requester ID.
- Holds the converter input stable for the whole conversion, because the converter samples its input bit-serially.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width; equals $clog2(N_REQ).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request.
- req_data  input  40*N_REQ  operand; requester i uses bits [40*i+39:40*i].
- req_ready  output  N_REQ  one-hot accept pulse.
- resp_valid  output  N_REQ  one-hot result pulse.
- resp_id  output  ID_W  index of the requester being answered.
- resp_bcd  output  40  BCD result, 10 digits.
- busy  output  1  high whenever the FSM is not in S_ARB.
- conv_trigger  output  1  converter start.
- conv_in  output  40  converter operand, registered.
- conv_idle  input  1  converter idle flag.
- conv_bcd  input  40  converter result.

Behaviour:
- Reset values (asynchronous):
  - state=S_SYNC, req_ready=0, resp_valid=0, resp_id=0, resp_bcd=0, conv_trigger=0, conv_in=0.
  - Priority pointer ptr=N_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- The converter has no reset, so after reset the block never triggers until conv_idle has been seen high.
- FSM states:
  - S_SYNC: wait for conv_idle=1, then go to S_ARB. Covers reset asserted mid-conversion.
  - S_ARB: if any req_valid bit is set, grant the first set bit searching ptr+1, ptr+2, ... modulo N_REQ.
    - Pulse req_ready[g] for one cycle.
    - Capture req_data slice g into conv_in.
    - Set ptr=g and go to S_LAUNCH.
    - With no request, stay in S_ARB; busy=0.
  - S_LAUNCH: conv_trigger=1 for exactly one cycle, then go to S_WAIT_BUSY.
  - S_WAIT_BUSY: wait for conv_idle=0, then go to S_WAIT_DONE.
  - S_WAIT_DONE: wait for conv_idle=1, then capture conv_bcd into resp_bcd and go to S_RESP.
  - S_RESP: resp_valid[ptr]=1 and resp_id=ptr for one cycle, then go to S_ARB.
- Output persistence:
  - resp_bcd and resp_id hold their values until the next response.
  - conv_in is held from capture until the next grant.
- Handshake rules:
  - A requester holds req_valid and data until it sees req_ready.
  - A requester may drop req_valid without penalty before it is granted.
  - Requesters cannot apply backpressure on resp_valid.
  - A requester may re-request in the cycle its resp_valid pulses.
  - The re-request is visible to the following S_ARB arbitration under normal round-robin order.
- Fairness:
  - With all requesters active, grants follow 0,1,..,N_REQ-1,0,...
  - A requester waits at most N_REQ-1 conversions.
- Simultaneous events: req_valid rising while the FSM is busy is ignored until S_ARB. There are no queued requests inside the block.
- Latency with the 40-bit converter:
  - Accept edge to trigger: 1 cycle.
  - Converter busy for 79 cycles.
  - resp_valid asserts 82 cycles after the req_ready cycle.
  - Minimum back-to-back throughput is one conversion per 84 cycles.
- Reset mid-operation: the FSM returns to S_SYNC and any pending response is discarded, with no resp_valid. conv_trigger is never asserted while conv_idle=0.
- Pointer and index rules: ptr wraps N_REQ-1 to 0. For N_REQ not a power of two, indices >= N_REQ are never granted.

Test Plan:
- Single request: req_valid[0]=1, data=40'd1234567890 -> req_ready[0] one pulse; conv_trigger one pulse; resp_valid=4'b0001, resp_id=0, resp_bcd=40'h1234567890, 82 cycles after accept.
- All four requesting continuously with data 0, 9, 255 and 40'hFF_FFFF_FFFF -> grants in order 0,1,2,3,0; results 0x0, 0x9, 0x255, and 40'h1099511627775 truncated per the converter (40'h1099511627775 low 40 bits); never two grants without a response in between.
- Round-robin skip: only requesters 1 and 3 active after a grant to 3 -> next grant is 1, then 3.
- Back-to-back: requester 2 re-asserts in its resp_valid cycle -> regranted in the next S_ARB cycle; busy low for exactly 1 cycle; conv_in stable throughout each conversion.
- Reset mid-conversion: assert reset at cycle 30 of a conversion while conv_idle=0 -> all outputs zero; no conv_trigger until conv_idle=1; no stale resp_valid; a new request converts correctly.
- Withdrawn request: req_valid[1] pulses high then low while the block is busy -> no grant to 1 and no resp_valid[1].
